// File: rtl/ec_fp_resource_share_if.sv
// Valid/ready stream bundle used on every port of the Fp core sharing block.
// Carries one data beat plus packet framing (sop/eop), a modifier bit, an error flag and a ctl tag.
interface if_axi_stream #(
  parameter int DAT_BITS = 32,
  parameter int CTL_BITS = 8
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                mod;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport master (output val, sop, eop, mod, err, dat, ctl, input rdy);
  modport slave  (input val, sop, eop, mod, err, dat, ctl, output rdy);
endinterface

// File: rtl/ec_fp_resource_share.sv
// N-to-1 sharing front end for one Fp arithmetic core: arbitrates channel requests into a tagged,
// registered core stream and routes core results back to the requesting channel by that tag.
module ec_fp_resource_share #(
  parameter int  NUM_CH   = 4,
  parameter int  DAT_BITS = 762,
  parameter int  RES_BITS = 381,
  parameter int  CTL_BITS = 16,
  parameter int  ARB_MODE = 0,
  parameter int  PKT_LOCK = 0,
  localparam int CH_BITS  = $clog2(NUM_CH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.slave   i_req_if [NUM_CH],
  if_axi_stream.master  o_res_if [NUM_CH],
  if_axi_stream.master  o_core_if,
  if_axi_stream.slave   i_core_if
);

  localparam logic [CH_BITS:0] NUM_CH_L = (CH_BITS+1)'(NUM_CH);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  logic [NUM_CH-1:0]   req_val, req_sop, req_eop, req_mod, req_err, req_rdy, res_rdy, res_sel;
  logic [DAT_BITS-1:0] req_dat [NUM_CH];
  logic [CTL_BITS-1:0] req_ctl [NUM_CH];

  logic [RES_BITS-1:0] res_dat;
  logic [CH_BITS-1:0]  res_tag;
  logic                res_tag_ok;
  logic                core_rdy;

  state_t                       state_q, state_d;
  logic [CH_BITS-1:0]           lock_idx_q, lock_idx_d;
  logic [CH_BITS-1:0]           ptr_q, ptr_d;
  logic                         core_val_q, core_val_d;
  logic                         core_sop_q, core_sop_d;
  logic                         core_eop_q, core_eop_d;
  logic                         core_mod_q, core_mod_d;
  logic                         core_err_q, core_err_d;
  logic [DAT_BITS-1:0]          core_dat_q, core_dat_d;
  logic [CTL_BITS+CH_BITS-1:0]  core_ctl_q, core_ctl_d;

  logic               gnt_vld;
  logic [CH_BITS-1:0] gnt_idx;
  logic [CH_BITS-1:0] rr_idx;
  int                 rr_j;
  logic               load_en;
  logic               accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign req_val[g] = i_req_if[g].val;
    assign req_sop[g] = i_req_if[g].sop;
    assign req_eop[g] = i_req_if[g].eop;
    assign req_mod[g] = i_req_if[g].mod;
    assign req_err[g] = i_req_if[g].err;
    assign req_dat[g] = i_req_if[g].dat;
    assign req_ctl[g] = i_req_if[g].ctl;
    assign i_req_if[g].rdy = req_rdy[g];

    assign o_res_if[g].val = i_core_if.val & res_sel[g];
    assign o_res_if[g].sop = i_core_if.sop;
    assign o_res_if[g].eop = i_core_if.eop;
    assign o_res_if[g].mod = i_core_if.mod;
    assign o_res_if[g].err = i_core_if.err;
    assign o_res_if[g].dat = res_dat;
    assign o_res_if[g].ctl = i_core_if.ctl[CTL_BITS-1:0];
    assign res_rdy[g] = o_res_if[g].rdy;
  end

  // Response routing: unknown tags are sunk so a bad beat cannot wedge the core.
  assign res_dat    = i_core_if.dat;
  assign res_tag    = i_core_if.ctl[CTL_BITS +: CH_BITS];
  assign res_tag_ok = {1'b0, res_tag} < NUM_CH_L;

  always_comb begin
    res_sel  = '0;
    core_rdy = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (res_tag_ok && res_tag == CH_BITS'(i)) begin
        res_sel[i] = 1'b1;
        core_rdy   = res_rdy[i];
      end
    end
  end

  assign i_core_if.rdy = core_rdy;

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_core_if.val)
      assert (res_tag_ok) else $error("ec_fp_resource_share: response tag %0d out of range", res_tag);
  end

  // Arbitration: descending scans let the lowest index (or nearest to ptr) overwrite the others.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    rr_idx  = '0;
    if (state_q == ST_LOCKED) begin
      gnt_vld = req_val[lock_idx_q];
      gnt_idx = lock_idx_q;
    end else if (ARB_MODE == 1) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req_val[CH_BITS'(i)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_BITS'(i);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        rr_j = int'(ptr_q) + i;
        if (rr_j >= NUM_CH) rr_j = rr_j - NUM_CH;
        rr_idx = CH_BITS'(rr_j);
        if (req_val[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  assign load_en = !core_val_q || o_core_if.rdy;
  assign accept  = load_en && gnt_vld && !i_rst;
  assign req_rdy = accept ? (NUM_CH'(1) << gnt_idx) : '0;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    core_val_d = core_val_q;
    core_sop_d = core_sop_q;
    core_eop_d = core_eop_q;
    core_mod_d = core_mod_q;
    core_err_d = core_err_q;
    core_dat_d = core_dat_q;
    core_ctl_d = core_ctl_q;
    if (load_en) core_val_d = gnt_vld;
    if (accept) begin
      core_sop_d = req_sop[gnt_idx];
      core_eop_d = req_eop[gnt_idx];
      core_mod_d = req_mod[gnt_idx];
      core_err_d = req_err[gnt_idx];
      core_dat_d = req_dat[gnt_idx];
      core_ctl_d = {gnt_idx, req_ctl[gnt_idx]};
      if (req_eop[gnt_idx])
        ptr_d = (gnt_idx == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_idx + CH_BITS'(1);
      if (PKT_LOCK != 0) begin
        if (req_eop[gnt_idx]) begin
          state_d = ST_IDLE;
        end else if (req_sop[gnt_idx]) begin
          state_d    = ST_LOCKED;
          lock_idx_d = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      core_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      core_val_q <= core_val_d;
    end
  end

  // Payload register is qualified by core_val_q, so it carries no reset.
  always_ff @(posedge i_clk) begin
    core_sop_q <= core_sop_d;
    core_eop_q <= core_eop_d;
    core_mod_q <= core_mod_d;
    core_err_q <= core_err_d;
    core_dat_q <= core_dat_d;
    core_ctl_q <= core_ctl_d;
  end

  assign o_core_if.val = core_val_q;
  assign o_core_if.sop = core_sop_q;
  assign o_core_if.eop = core_eop_q;
  assign o_core_if.mod = core_mod_q;
  assign o_core_if.err = core_err_q;
  assign o_core_if.dat = core_dat_q;
  assign o_core_if.ctl = core_ctl_q;

endmodule

// File: tb/tb_ec_fp_resource_share.sv
// Bench for ec_fp_resource_share: round-robin + packet-lock instance with a scoreboard model,
// response-routing vector table, and a fixed-priority instance.
module tb_ec_fp_resource_share;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 16;
  localparam int CW = 8;
  localparam int TW = CW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) a_req [N] ();
  if_axi_stream #(.DAT_BITS(RW), .CTL_BITS(CW)) a_res [N] ();
  if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(TW)) a_co ();
  if_axi_stream #(.DAT_BITS(RW), .CTL_BITS(TW)) a_ci ();
  if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) b_req [N] ();
  if_axi_stream #(.DAT_BITS(RW), .CTL_BITS(CW)) b_res [N] ();
  if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(TW)) b_co ();
  if_axi_stream #(.DAT_BITS(RW), .CTL_BITS(TW)) b_ci ();

  logic          a_val [N], a_sop [N], a_eop [N], a_rdy [N], a_rrdy [N], a_rval [N];
  logic [DW-1:0] a_dat [N];
  logic [CW-1:0] a_ctl [N], a_rctl [N];
  logic [RW-1:0] a_rdat [N];
  logic          a_co_rdy;
  logic          b_val [N], b_rdy [N];

  for (genvar g = 0; g < N; g++) begin : g_tb
    assign a_req[g].val = a_val[g];
    assign a_req[g].sop = a_sop[g];
    assign a_req[g].eop = a_eop[g];
    assign a_req[g].mod = 1'b0;
    assign a_req[g].err = 1'b0;
    assign a_req[g].dat = a_dat[g];
    assign a_req[g].ctl = a_ctl[g];
    assign a_rdy[g]     = a_req[g].rdy;
    assign a_res[g].rdy = a_rrdy[g];
    assign a_rval[g]    = a_res[g].val;
    assign a_rdat[g]    = a_res[g].dat;
    assign a_rctl[g]    = a_res[g].ctl;

    assign b_req[g].val = b_val[g];
    assign b_req[g].sop = 1'b1;
    assign b_req[g].eop = 1'b1;
    assign b_req[g].mod = 1'b0;
    assign b_req[g].err = 1'b0;
    assign b_req[g].dat = DW'(g);
    assign b_req[g].ctl = '0;
    assign b_rdy[g]     = b_req[g].rdy;
    assign b_res[g].rdy = 1'b1;
  end

  assign a_co.rdy = a_co_rdy;
  assign b_co.rdy = 1'b1;
  assign b_ci.val = 1'b0;
  assign b_ci.sop = 1'b0;
  assign b_ci.eop = 1'b0;
  assign b_ci.mod = 1'b0;
  assign b_ci.err = 1'b0;
  assign b_ci.dat = '0;
  assign b_ci.ctl = '0;

  ec_fp_resource_share #(.NUM_CH(N), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW),
                         .ARB_MODE(0), .PKT_LOCK(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_if(a_req), .o_res_if(a_res),
    .o_core_if(a_co), .i_core_if(a_ci));

  ec_fp_resource_share #(.NUM_CH(N), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW),
                         .ARB_MODE(1), .PKT_LOCK(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_if(b_req), .o_res_if(b_res),
    .o_core_if(b_co), .i_core_if(b_ci));

  // Reference model: queue of beats owed to the core, plus arbitration pointer and lock owner.
  typedef struct { logic [DW-1:0] dat; logic [TW-1:0] ctl; } beat_t;
  beat_t         exp_q [$];
  int            m_ptr = 0;
  int            m_lock = -1;
  int            acc_ch = -1;
  int            acc_cnt [N];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat;
  logic [TW-1:0] prev_ctl;

  typedef struct { logic [1:0] tag; logic cval; logic [3:0] rrdy; logic [3:0] xval; logic xrdy; } rsp_vec_t;
  rsp_vec_t rv [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Lock owner if locked, else the valid channel at the smallest circular distance from ptr.
  function automatic int pick();
    int best = -1;
    int bd = N;
    if (m_lock >= 0) return a_val[m_lock] ? m_lock : -1;
    for (int c = 0; c < N; c++)
      if (a_val[c] && ((c - m_ptr + N) % N) < bd) begin
        bd = (c - m_ptr + N) % N;
        best = c;
      end
    return best;
  endfunction

  task automatic cycle_a();
    logic [N-1:0] rdy_v, req_v;
    logic         load_ok;
    int           exp_ch;
    beat_t        b;
    #1;
    acc_ch = -1;
    chk("core_val", a_co.val, exp_q.size() != 0);
    load_ok = (exp_q.size() == 0) || a_co_rdy;
    if (a_co.val && prev_stall) begin
      chk("hold_dat", a_co.dat, prev_dat);
      chk("hold_ctl", a_co.ctl, prev_ctl);
    end
    if (a_co.val && a_co_rdy && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      chk("core_dat", a_co.dat, b.dat);
      chk("core_ctl", a_co.ctl, b.ctl);
    end
    prev_stall = a_co.val && !a_co_rdy;
    prev_dat   = a_co.dat;
    prev_ctl   = a_co.ctl;
    exp_ch = (!rst && load_ok) ? pick() : -1;
    for (int c = 0; c < N; c++) begin
      rdy_v[c] = a_rdy[c];
      req_v[c] = (c == exp_ch);
    end
    chk("req_rdy", rdy_v, req_v);
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
      m_lock = -1;
      prev_stall = 1'b0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (a_val[c] && a_rdy[c]) begin
          b.dat = a_dat[c];
          b.ctl = {2'(c), a_ctl[c]};
          exp_q.push_back(b);
          acc_ch = c;
          acc_cnt[c]++;
          if (a_eop[c]) begin
            m_lock = -1;
            m_ptr = (c + 1) % N;
          end else if (a_sop[c]) begin
            m_lock = c;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic refresh(input bit pkt);
    for (int c = 0; c < N; c++) begin
      if (!a_val[c] || acc_ch == c) begin
        a_val[c] = 1'($urandom % 2);
        a_dat[c] = $urandom;
        a_ctl[c] = 8'($urandom);
        a_sop[c] = pkt ? 1'($urandom % 2) : 1'b1;
        a_eop[c] = pkt ? 1'($urandom % 2) : 1'b1;
      end
    end
  endtask

  initial begin
    int log_q [$];
    int k;
    logic [N-1:0] v4;

    rv[0] = '{2'd0, 1'b1, 4'b1111, 4'b0001, 1'b1};
    rv[1] = '{2'd1, 1'b1, 4'b1101, 4'b0010, 1'b0};
    rv[2] = '{2'd2, 1'b1, 4'b0100, 4'b0100, 1'b1};
    rv[3] = '{2'd3, 1'b1, 4'b0111, 4'b1000, 1'b0};
    rv[4] = '{2'd3, 1'b0, 4'b1000, 4'b0000, 1'b1};
    rv[5] = '{2'd2, 1'b0, 4'b1011, 4'b0000, 1'b0};

    for (int c = 0; c < N; c++) begin
      a_val[c] = 1'b1; a_sop[c] = 1'b1; a_eop[c] = 1'b1;
      a_dat[c] = '0; a_ctl[c] = '0; a_rrdy[c] = 1'b1; acc_cnt[c] = 0;
      b_val[c] = 1'b0;
    end
    a_co_rdy = 1'b1;
    a_ci.val = 1'b0; a_ci.sop = 1'b1; a_ci.eop = 1'b1; a_ci.mod = 1'b0; a_ci.err = 1'b0;
    a_ci.dat = '0; a_ci.ctl = '0;

    // Reset with all channels requesting: no rdy, no val anywhere.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cycle_a();
    for (int c = 0; c < N; c++) v4[c] = a_rval[c];
    chk("rst_res_val", v4, 4'b0000);
    for (int c = 0; c < N; c++) a_val[c] = 1'b0;
    rst = 1'b0;
    cycle_a();

    // Response routing table.
    for (int i = 0; i < 6; i++) begin
      a_ci.val = rv[i].cval;
      a_ci.ctl = {rv[i].tag, 8'(8'h3C + i)};
      a_ci.dat = 16'(16'h1230 + i);
      for (int c = 0; c < N; c++) a_rrdy[c] = rv[i].rrdy[c];
      #1;
      for (int c = 0; c < N; c++) v4[c] = a_rval[c];
      chk("rsp_val", v4, rv[i].xval);
      chk("rsp_rdy", a_ci.rdy, rv[i].xrdy);
      chk("rsp_dat", a_rdat[(rv[i].tag + 1) % N], 16'(16'h1230 + i));
      chk("rsp_ctl", a_rctl[(rv[i].tag + 1) % N], 8'(8'h3C + i));
      @(negedge clk);
    end
    a_ci.val = 1'b0;
    for (int c = 0; c < N; c++) a_rrdy[c] = 1'b1;

    // Fixed-priority instance: channel 1 beats channel 3 until it drops.
    b_val[1] = 1'b1; b_val[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      for (int c = 0; c < N; c++) v4[c] = b_rdy[c];
      chk("prio_rdy", v4, 4'b0010);
      if (i > 0) chk("prio_tag", b_co.ctl[CW +: 2], 2'd1);
      @(negedge clk);
    end
    b_val[1] = 1'b0;
    #1;
    for (int c = 0; c < N; c++) v4[c] = b_rdy[c];
    chk("prio_rdy3", v4, 4'b1000);
    @(negedge clk);
    #1;
    chk("prio_tag3", b_co.ctl[CW +: 2], 2'd3);
    b_val[3] = 1'b0;
    @(negedge clk);

    // Round-robin fairness: 16 beats, all channels valid.
    for (int c = 0; c < N; c++) begin
      a_val[c] = 1'b1; a_sop[c] = 1'b1; a_eop[c] = 1'b1; a_dat[c] = $urandom; acc_cnt[c] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) chk("rr_busy", a_co.val, 1'b1);
      cycle_a();
      chk("rr_order", acc_ch, i % N);
      if (acc_ch >= 0) a_dat[acc_ch] = $urandom;
    end
    for (int c = 0; c < N; c++) begin
      chk("rr_count", acc_cnt[c], 4);
      a_val[c] = 1'b0;
    end
    cycle_a();

    // Packet lock: 3-beat packet on channel 0 is not interleaved with channel 1.
    k = 0;
    a_val[0] = 1'b1; a_sop[0] = 1'b1; a_eop[0] = 1'b0; a_dat[0] = 32'hA0;
    a_val[1] = 1'b1; a_sop[1] = 1'b1; a_eop[1] = 1'b1; a_dat[1] = 32'hB0;
    for (int i = 0; i < 10 && log_q.size() < 4; i++) begin
      cycle_a();
      if (acc_ch >= 0) log_q.push_back(acc_ch);
      if (acc_ch == 0) begin
        k++;
        a_sop[0] = 1'b0;
        a_eop[0] = (k == 2);
        a_dat[0] = 32'(32'hA0 + k);
        if (k == 3) a_val[0] = 1'b0;
      end
      if (acc_ch == 1) a_val[1] = 1'b0;
    end
    chk("lock_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("lock_order", log_q[i], (i < 3) ? 0 : 1);
    a_val[0] = 1'b0; a_val[1] = 1'b0;
    cycle_a();

    // Single channel through a behavioural multiplier core: 3 * 5 on channel 2.
    a_val[2] = 1'b1; a_sop[2] = 1'b1; a_eop[2] = 1'b1;
    a_dat[2] = {16'd3, 16'd5}; a_ctl[2] = 8'hA5;
    cycle_a();
    chk("mul_acc", acc_ch, 2);
    a_val[2] = 1'b0;
    a_ci.val = 1'b1;
    a_ci.dat = a_co.dat[31:16] * a_co.dat[15:0];
    a_ci.ctl = a_co.ctl;
    #1;
    for (int c = 0; c < N; c++) v4[c] = a_rval[c];
    chk("mul_val", v4, 4'b0100);
    chk("mul_dat", a_rdat[2], 16'd15);
    chk("mul_ctl", a_rctl[2], 8'hA5);
    chk("mul_core_rdy", a_ci.rdy, 1'b1);
    cycle_a();
    a_ci.val = 1'b0;

    // Backpressure: core rdy toggles 1010 with random single-beat requests.
    for (int i = 0; i < 200; i++) begin
      a_co_rdy = (i % 2 == 0);
      refresh(1'b0);
      cycle_a();
    end

    // Random traffic with multi-beat framing and a mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      a_co_rdy = ($urandom % 4) != 0;
      rst = (i == 150);
      refresh(1'b1);
      cycle_a();
    end
    rst = 1'b0;

    // Reset then first grant goes to the lowest-index valid channel.
    rst = 1'b1;
    a_co_rdy = 1'b1;
    for (int c = 0; c < N; c++) begin
      a_val[c] = (c >= 2); a_sop[c] = 1'b1; a_eop[c] = 1'b1;
    end
    cycle_a();
    rst = 1'b0;
    chk("rst_core_val", a_co.val, 1'b0);
    cycle_a();
    chk("rst_first_grant", acc_ch, 2);
    for (int c = 0; c < N; c++) a_val[c] = 1'b0;
    repeat (3) cycle_a();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
